// File: rtl/calc_cmd_seq_if.sv
// Request/response and token-stream bundle between a host, the command sequencer and the calculator.
// The master side is the environment: the host driving requests plus the calculator supplying calcData.
interface calc_cmd_seq_if;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic [15:0] reqA;
    logic [15:0] reqB;
    logic        tokValid;
    logic [15:0] tokData;
    logic [15:0] calcData;
    logic        rspValid;
    logic [15:0] rspData;
    logic        rspErr;
    logic [7:0]  errCount;

    modport master (
        output reqValid, reqOp, reqA, reqB, calcData,
        input  reqReady, tokValid, tokData, rspValid, rspData, rspErr, errCount
    );

    modport slave (
        input  reqValid, reqOp, reqA, reqB, calcData,
        output reqReady, tokValid, tokData, rspValid, rspData, rspErr, errCount
    );
endinterface

// File: rtl/calc_cmd_seq.sv
// Serializes one arithmetic request into calculator tokens, captures the result and
// flags it against a locally computed expected value.
module calc_cmd_seq #(
    parameter int unsigned GAP = 0
) (
    input  logic           clk,
    input  logic           rst,
    calc_cmd_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_A  = 3'd1,
        SEND_OP = 3'd2,
        SEND_B  = 3'd3,
        PAUSE   = 3'd4,
        WAIT    = 3'd5
    } state_t;

    localparam bit       HAS_GAP  = (GAP != 0);
    localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t      state_reg, state_next;
    state_t      ret_reg, ret_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;

    logic [15:0] a_reg, b_reg, exp_reg;
    logic [1:0]  op_reg;
    logic        rsp_valid_reg;
    logic [15:0] rsp_data_reg;
    logic        rsp_err_reg;
    logic [7:0]  err_count_reg;

    logic        accept;
    logic        req_ready;
    logic        tok_valid;
    logic [15:0] tok_data;
    logic [15:0] exp_calc;
    logic        mismatch;

    // Expected result is fixed at accept time so later operand changes cannot affect it.
    always_comb begin
        exp_calc = 16'd0;
        case (bus.reqOp)
            2'd0: exp_calc = bus.reqA * bus.reqB;
            2'd1: exp_calc = bus.reqA + bus.reqB;
            2'd2: exp_calc = bus.reqA * bus.reqA;
            default: exp_calc = bus.reqA + 16'd1;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        ret_next     = ret_reg;
        gap_cnt_next = gap_cnt_reg;
        req_ready    = 1'b0;
        accept       = 1'b0;
        tok_valid    = 1'b0;
        tok_data     = 16'd0;

        case (state_reg)
            IDLE: begin
                // Reset must win over a concurrent request.
                req_ready = ~rst;
                accept    = req_ready & bus.reqValid;
                if (accept) begin
                    state_next = SEND_A;
                end
            end
            SEND_A: begin
                tok_valid = 1'b1;
                tok_data  = a_reg;
                if (HAS_GAP) begin
                    state_next   = PAUSE;
                    ret_next     = SEND_OP;
                    gap_cnt_next = 8'd0;
                end else begin
                    state_next = SEND_OP;
                end
            end
            SEND_OP: begin
                tok_valid = 1'b1;
                tok_data  = {14'd0, op_reg};
                if (op_reg[1]) begin
                    state_next = WAIT;
                end else if (HAS_GAP) begin
                    state_next   = PAUSE;
                    ret_next     = SEND_B;
                    gap_cnt_next = 8'd0;
                end else begin
                    state_next = SEND_B;
                end
            end
            SEND_B: begin
                tok_valid  = 1'b1;
                tok_data   = b_reg;
                state_next = WAIT;
            end
            PAUSE: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ret_reg;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mismatch = (bus.calcData != exp_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ret_reg       <= IDLE;
            gap_cnt_reg   <= 8'd0;
            a_reg         <= 16'd0;
            b_reg         <= 16'd0;
            op_reg        <= 2'd0;
            exp_reg       <= 16'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 16'd0;
            rsp_err_reg   <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            ret_reg       <= ret_next;
            gap_cnt_reg   <= gap_cnt_next;
            rsp_valid_reg <= (state_reg == WAIT);
            if (accept) begin
                a_reg   <= bus.reqA;
                b_reg   <= bus.reqB;
                op_reg  <= bus.reqOp;
                exp_reg <= exp_calc;
            end
            // The calculator's registered result is valid one cycle after the last token.
            if (state_reg == WAIT) begin
                rsp_data_reg <= bus.calcData;
                rsp_err_reg  <= mismatch;
                if (mismatch && (err_count_reg != 8'hFF)) begin
                    err_count_reg <= err_count_reg + 8'd1;
                end
            end
        end
    end

    assign bus.reqReady = req_ready;
    assign bus.tokValid = tok_valid;
    assign bus.tokData  = tok_data;
    assign bus.rspValid = rsp_valid_reg;
    assign bus.rspData  = rsp_data_reg;
    assign bus.rspErr   = rsp_err_reg;
    assign bus.errCount = err_count_reg;

endmodule

// File: doc/calc_cmd_seq.md
# calc_cmd_seq

Command sequencer at the initiator end of the calculator token interface. Accepts one arithmetic request per handshake (operand A, operator, optional operand B), serializes it into the calculator's token stream (validIn/dataIn), samples the calculator's registered result, and returns it with a pass/fail flag against an internally computed expected value. Sits between a test/host controller and the calculator datapath; both blocks share clk and rst.

## Interface
- GAP, 0, idle cycles (tokValid low) inserted between consecutive tokens of one request; legal 0..255
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- reqValid  input  1  request present
- reqReady  output  1  sequencer can accept a request
- reqOp  input  2  0 multiply, 1 add, 2 square, 3 increment
- reqA  input  16  first operand
- reqB  input  16  second operand; ignored for reqOp 2 and 3
- tokValid  output  1  token valid, drives calculator validIn
- tokData  output  16  token value, drives calculator dataIn
- calcData  input  16  calculator dataOut
- rspValid  output  1  one-cycle pulse, response fields valid
- rspData  output  16  captured calculator result
- rspErr  output  1  rspData differs from expected
- errCount  output  8  count of rspErr pulses, saturates at 255

## Operation
- States: IDLE, SEND_A, SEND_OP, SEND_B, PAUSE, WAIT.
- IDLE: reqReady=1. reqValid&&reqReady captures reqA, reqOp, reqB and registers expected result; next SEND_A.
- SEND_A: tokValid=1, tokData=A. Next PAUSE (return SEND_OP) if GAP>0, else SEND_OP.
- SEND_OP: tokValid=1, tokData={14'b0, op}. op 0/1: next PAUSE→SEND_B or SEND_B. op 2/3: next WAIT.
- SEND_B: tokValid=1, tokData=B. Next WAIT.
- PAUSE: tokValid=0, tokData=0; counts GAP cycles then enters stored return state. Never entered when GAP=0.
- WAIT: tokValid=0; registers rspData<=calcData, rspErr<=(calcData!=expected), rspValid<=1 for the following cycle; errCount increments (saturating) if mismatch; next IDLE.
- Expected (all modulo 2^16, low 16 bits kept): op0 A*B, op1 A+B, op2 A*A, op3 A+1.
- tokData=0 whenever tokValid=0. Operator codes >=4 never emitted.
- Requests are not queued: reqReady=0 in every state except IDLE; reqValid ignored there.
- Outputs rspData/rspErr hold last values until next WAIT; rspValid is high exactly one cycle per request.

## Timing
- Reset values: reqReady=0 during rst cycle then 1 in IDLE; tokValid=0, tokData=0, rspValid=0, rspData=0, rspErr=0, errCount=0, state IDLE.
- Calculator registers each token at the edge ending its tokValid cycle; result is read from calcData in WAIT, one cycle after the last token.
- GAP=0, binary op, accept in cycle 0: tokens cycles 1,2,3; WAIT cycle 4; rspValid cycle 5; reqReady high again cycle 5 (back-to-back accept allowed concurrent with rspValid).
- GAP=0, unary op: tokens cycles 1,2; WAIT cycle 3; rspValid cycle 4.
- GAP=g: binary latency 5+2g cycles accept→rspValid; unary 4+g.
- rst mid-request: return to IDLE next cycle, drop in-flight request, no rspValid; calculator sharing rst also returns to its operand state, keeping streams aligned.
- rst asserted same cycle as rspValid: rspValid still low after the edge, errCount cleared.

## Test plan
- Reset: hold rst 2 cycles mid SEND_OP -> all outputs at reset values, tokValid=0 next cycle, reqReady=1 after release.
- GAP=0, A=7 op=0 B=6 with real calculator -> tokens 7,0,6 on cycles 1–3, rspValid cycle 5, rspData=42, rspErr=0.
- GAP=0, A=0xFFFF op=3 -> tokens 0xFFFF,3 only, rspData=0x0000, rspErr=0; A=0x0100 op=2 -> rspData=0x0000 (wrap).
- GAP=3, A=100 op=1 B=23 -> 3 idle cycles between tokens, rspValid 11 cycles after accept, rspData=123.
- Faulty calculator model forcing calcData=0x1234 -> rspErr=1, errCount increments per request, saturates at 255 after 300 requests.
- Back-to-back: reqValid held high with 4 requests -> each accepted in the rspValid cycle of the previous, reqValid ignored while reqReady=0, no token gaps beyond GAP.
